// File: rtl/spi_ddr_master_pkg.sv
// ---------------------------------------------------------------------------
// spi_ddr_master_pkg
// Shared definitions for the SPI DDR master and its lane capture blocks:
//   - state_t        : frame FSM encoding (also exported on the debug port)
//   - WORDS_PER_LANE : each lane returns one rising-edge and one falling-edge word
//   - lane_slice_w() : bits per lane in the packed rxd bus (2*DW)
//   - clog2_f()      : ceiling log2 used to size counters
// Optional feature macro (used by spi_lane_capture): SPI_DDR_SAMPLE_EN
// ---------------------------------------------------------------------------
package spi_ddr_master_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_STOP  = 3'd4,
    S_GAP   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int unsigned WORDS_PER_LANE = 2;

  function automatic int unsigned lane_slice_w(input int unsigned dw);
    return WORDS_PER_LANE * dw;
  endfunction

  // Smallest r with 2**r >= v; clog2_f(1) = 0.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_ddr_master_lane.sv
// ---------------------------------------------------------------------------
// spi_lane_capture
// Per-lane miso deserialiser. Two MSB-first shift registers: one loaded on
// rise strobes, one on fall strobes. Output word is {rise_word, fall_word}.
// Optional feature macro: SPI_DDR_SAMPLE_EN. When undefined, the falling
// word is not captured and reads as zero; the output width is unchanged.
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   i_miso        : serial data from this lane
//   i_rise_stb    : shift i_miso into the rising-edge word
//   i_fall_stb    : shift i_miso into the falling-edge word
//   i_clear       : zero both words at the start of a frame
//   o_word        : {rising word, falling word}, 2*DW bits
// ---------------------------------------------------------------------------
module spi_lane_capture
  import spi_ddr_master_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_miso,
  input  logic                        i_rise_stb,
  input  logic                        i_fall_stb,
  input  logic                        i_clear,
  output logic [lane_slice_w(DW)-1:0] o_word
);

  logic [DW-1:0] r_rise;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_rise <= '0;
    end else if (i_rise_stb) begin
      r_rise <= (r_rise << 1) | DW'(i_miso);
    end
  end

`ifdef SPI_DDR_SAMPLE_EN
  logic [DW-1:0] r_fall;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_fall <= '0;
    end else if (i_fall_stb) begin
      r_fall <= (r_fall << 1) | DW'(i_miso);
    end
  end

  assign o_word = {r_rise, r_fall};
`else
  logic w_unused_fall;
  assign w_unused_fall = i_fall_stb;
  assign o_word        = {r_rise, {DW{1'b0}}};
`endif

endmodule

// File: rtl/spi_ddr_master.sv
// ---------------------------------------------------------------------------
// spi_ddr_master
// One chip-select frame per fs request: shifts a DW-bit command out on mosi
// (MSB first, SPI mode 0) while capturing NLANE miso lanes on sclk rising
// edges and, with SPI_DDR_SAMPLE_EN defined, also on falling edges.
// Optional feature macro: SPI_DDR_SAMPLE_EN (falling-edge capture).
//
// Request handshake: fs is a level request. A frame starts when fs is seen
// high in WAIT; fd_spi rises together with cs and stays high until fs is
// seen low, so each high level of fs yields exactly one frame. fs changes
// during a frame are ignored.
//
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   fs           : frame start request (level)
//   txd[DW]      : command word, captured when the frame is accepted
//   fd_spi       : frame done, cs rising until fs low
//   busy         : frame in progress (LOAD through GAP)
//   sclk/mosi/cs : SPI pins, cs active low
//   miso[NLANE]  : per-lane serial data
//   rxd          : lane l at [(l+1)*2DW-1 : l*2DW], {rise word, fall word}
//   o_dbg_state  : current FSM state
//
// Every output is a register whose next value is derived from the next
// state, so cs is low for exactly the LOAD, SHIFT and STOP cycles.
// ---------------------------------------------------------------------------
module spi_ddr_master
  import spi_ddr_master_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter int unsigned NLANE  = 2,
  parameter int unsigned CLKDIV = 4,
  parameter int unsigned CS_GAP = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fs,
  input  logic [DW-1:0]         txd,
  output logic                  fd_spi,
  output logic                  busy,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs,
  input  logic [NLANE-1:0]      miso,
  output logic [NLANE*2*DW-1:0] rxd,
  output state_t                o_dbg_state
);

  localparam int unsigned H  = CLKDIV / 2;
  localparam int unsigned SW = lane_slice_w(DW);
  localparam int unsigned BW = clog2_f(DW) + 1;
  localparam int unsigned HW = clog2_f(H) + 1;
  localparam int unsigned GW = clog2_f(CS_GAP) + 1;

  state_t                r_state;
  state_t                w_next;
  logic                  r_cs;
  logic                  r_sclk;
  logic                  r_mosi;
  logic                  r_fd;
  logic                  r_busy;
  logic [DW-1:0]         r_tx;
  logic [BW-1:0]         r_bit;
  logic [HW-1:0]         r_hcnt;
  logic [GW-1:0]         r_gap;
  logic [NLANE*SW-1:0]   r_rxd;

  logic                  w_half_end;
  logic                  w_rise_stb;
  logic                  w_fall_stb;
  logic                  w_last;
  logic                  w_clear;
  logic [DW-1:0]         w_tx_sh;
  logic [NLANE*SW-1:0]   w_lane_words;

  // r_sclk doubles as the half-period phase: 1 = high half, 0 = low half.
  assign w_half_end = (r_state == S_SHIFT) && (r_hcnt == HW'(H - 1));
  assign w_rise_stb = w_half_end && r_sclk;
  assign w_fall_stb = w_half_end && !r_sclk;
  assign w_last     = w_fall_stb && (r_bit == BW'(DW - 1));
  assign w_clear    = (r_state == S_LOAD);
  assign w_tx_sh    = r_tx << 1;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  w_next = S_WAIT;
      S_WAIT:  if (fs) w_next = S_LOAD;
      S_LOAD:  w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_STOP;
      S_STOP:  w_next = S_GAP;
      S_GAP:   if (r_gap == GW'(CS_GAP - 1)) w_next = S_DONE;
      S_DONE:  if (!fs) w_next = S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cs    <= 1'b1;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_fd    <= 1'b0;
      r_busy  <= 1'b0;
      r_tx    <= '0;
      r_bit   <= '0;
      r_hcnt  <= '0;
      r_gap   <= '0;
      r_rxd   <= '0;
    end else begin
      r_state <= w_next;
      r_cs    <= !(w_next inside {S_LOAD, S_SHIFT, S_STOP});
      // STOP is included so busy does not dip between SHIFT and GAP.
      r_busy  <= (w_next inside {S_LOAD, S_SHIFT, S_STOP, S_GAP});
      r_fd    <= (w_next inside {S_GAP, S_DONE});

      if (w_next != S_SHIFT)     r_sclk <= 1'b0;
      else if (r_state == S_LOAD) r_sclk <= 1'b1;
      else if (w_half_end)        r_sclk <= ~r_sclk;

      // mosi moves to the next bit at the end of each low half; the zero
      // shifted in behind bit 0 is what mosi shows once the word is sent.
      if (w_next == S_LOAD) begin
        r_mosi <= txd[DW-1];
      end else if (w_next == S_SHIFT) begin
        if (w_fall_stb) r_mosi <= w_tx_sh[DW-1];
      end else begin
        r_mosi <= 1'b0;
      end

      if (w_next == S_LOAD) r_tx <= txd;
      else if (w_fall_stb)  r_tx <= w_tx_sh;

      if (r_state == S_SHIFT && !w_half_end) r_hcnt <= r_hcnt + 1'b1;
      else                                   r_hcnt <= '0;

      if (r_state != S_SHIFT) r_bit <= '0;
      else if (w_fall_stb)    r_bit <= r_bit + 1'b1;

      if (r_state == S_GAP) r_gap <= r_gap + 1'b1;
      else                  r_gap <= '0;

      if (r_state == S_STOP) r_rxd <= w_lane_words;
    end
  end

  for (genvar l = 0; l < NLANE; l++) begin : g_lane
    spi_lane_capture #(.DW(DW)) u_lane (
      .clk        (clk),
      .rst        (rst),
      .i_miso     (miso[l]),
      .i_rise_stb (w_rise_stb),
      .i_fall_stb (w_fall_stb),
      .i_clear    (w_clear),
      .o_word     (w_lane_words[l*SW +: SW])
    );
  end

  assign cs          = r_cs;
  assign sclk        = r_sclk;
  assign mosi        = r_mosi;
  assign fd_spi      = r_fd;
  assign busy        = r_busy;
  assign rxd         = r_rxd;
  assign o_dbg_state = r_state;

endmodule
